load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential access controller between the CPU memory stage and the byte-addressed 64-bit data `memory`. It accepts one load or store request at a time through a valid/ready handshake and drives the memory's `read`, `write`, `address` and `d_in` pins. Sub-word stores are done as read-modify-write, because the memory always writes 8 bytes. The unit also sign- or zero-extends load data and faults misaligned or out-of-range requests without touching memory.

## Interface
- `MEM_SIZE`, default 256: byte capacity of the attached memory; used for the range check.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept; equals `state==IDLE && !reset`.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word, 11 double.
- `req_signed` input 1: sign-extend a load; ignored for double and for stores.
- `req_addr` input 64: byte address.
- `req_wdata` input 64: store data, right-aligned.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 64: extended load data; 0 for stores and faults.
- `resp_fault` output 1: request rejected; valid with `resp_valid`.
- `mem_address` output 64: to memory `address`; always the latched request address.
- `mem_d_in` output 64: to memory `d_in`.
- `mem_read` output 1: to memory `read`.
- `mem_write` output 1: to memory `write`.
- `mem_d_out` input 64: from memory `d_out`; little-endian, byte at `address` in bits [7:0].

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- In IDLE, `req_valid && req_ready` latches addr, size, signed, write and wdata. The next state is chosen as follows:
  - Fault (misaligned, or `addr > MEM_SIZE-8` unsigned): RESP with fault.
  - Load: READ.
  - Double store: WRITE.
  - Sub-word store: READ.
- Alignment rule:
  - Byte: always aligned.
  - Half: requires `addr[0]==0`.
  - Word: requires `addr[1:0]==0`.
  - Double: requires `addr[2:0]==0`.
- Range rule: every access touches 8 bytes, so any size at `addr > MEM_SIZE-8` faults.
- READ: assert `mem_read=1` and capture `mem_d_out` at the closing edge. A load then goes to RESP. A sub-word store goes to WRITE.
- Load extension: take the low 8/16/32/64 bits, then sign- or zero-extend to 64 bits.
- WRITE: assert `mem_write=1`; the memory commits at the closing edge, then go to RESP.
  - Double store: `mem_d_in = wdata`.
  - Sub-word store: low N bytes of `mem_d_in` come from `wdata`; the upper 8-N bytes come from the captured read data.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE. There is no response backpressure.
- `mem_read` and `mem_write` are never high together. Both are 0 outside READ and WRITE respectively, and both are 0 while `reset` is high.
- `mem_d_in` is 0 outside WRITE.

## Timing
- Accept edge E0.
- Load: READ in cycle E0→E1, RESP in E1→E2. `req_ready` returns after E2, so the unit takes 3 cycles per load.
- Double store: WRITE then RESP, 3 cycles.
- Sub-word store: READ, WRITE, RESP, 4 cycles.
- Fault: RESP immediately, 2 cycles. No memory strobe is asserted.
- Reset values:
  - State: IDLE.
  - All latches: 0.
  - `resp_valid`, `resp_fault`, `resp_rdata`, `mem_read`, `mem_write`, `mem_d_in`, `mem_address`: all 0.
  - `req_ready`: 0 while `reset` is asserted.
- Reset mid-operation: the state returns to IDLE asynchronously and `mem_write` drops immediately, so a store aborted before its WRITE edge leaves memory unchanged. No response is issued for the aborted request.
- `req_valid` while not ready is ignored. The requester holds the request until it sees `req_ready`.

## Structure
- `lsu_pkg` holds:
  - the size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`;
  - the FSM state encoding;
  - a function returning the byte count for each size.
- Sub-module `lsu_align` is combinational. It contains the extend path (size, signed, raw → rdata) and the merge path (size, wdata, old → mem_d_in). The top level holds the FSM, latches and fault check.

## Test plan
- Memory dword at 0x10 preloaded with 0x8877665544332211; signed byte load at 0x17 → `resp_rdata` 0xFFFFFFFFFFFFFF88, fault 0, `resp_valid` 2 cycles after accept.
- Unsigned half load at 0x16 → 0x0000000000008877. Signed word load at 0x14 → 0xFFFFFFFF88776655.
- Byte store 0xAB at 0x12 → dword at 0x10 reads 0x8877665544AB2211. Bytes 0x18–0x19 unchanged. Exactly one `mem_write` pulse, preceded by one `mem_read` pulse.
- Word load at 0x12 (misaligned), then byte load at 0xF9 (out of range) → each gives `resp_fault=1` and `resp_rdata=0`, with no `mem_read` or `mem_write` asserted.
- Double store 0x0123456789ABCDEF at 0x20 → the following double load at 0x20 returns the same value. `req_ready` is low for exactly 2 cycles per request.
- Reset asserted during the WRITE cycle of a byte store to 0x12 → `mem_write` falls immediately, memory is unchanged, no `resp_valid`, and `req_ready=1` the cycle after reset is released.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: size and state encodings shared by the load/store unit and its datapath.
package lsu_pkg;

    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_t;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    function automatic logic [3:0] size_bytes(input size_t size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: load extension and sub-word store merge.
// The datapath is combinational and is built from a low-byte mask that is derived from the access size.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [63:0] raw,
    input  logic [63:0] wdata,
    input  logic [63:0] old,
    output logic [63:0] rdata,
    output logic [63:0] merged
);

    logic [63:0] mask;
    logic [5:0]  msb;

    always_comb begin
        mask = {64{1'b1}} >> (7'd64 - {size_bytes(size_t'(size)), 3'b000});
        msb  = 6'({size_bytes(size_t'(size)), 3'b000} - 7'd1);
    end

    // For a double access the mask is all ones, so the sign fill vanishes on its own.
    assign rdata  = (raw & mask) | ((sign && raw[msb]) ? ~mask : 64'd0);
    assign merged = (wdata & mask) | (old & ~mask);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store controller for a 64-bit byte-addressed memory.
// Sub-word stores are performed as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 256
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] mem_address,
    output logic [63:0] mem_d_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_d_out
);

    state_t      state;
    logic [1:0]  size;
    logic        sign;
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] ext_data;
    logic [63:0] merge_data;
    logic        fault;

    // Every access moves 8 bytes, so the range limit is the same for all sizes.
    always_comb
        fault = ((req_addr[2:0] & 3'(size_bytes(size_t'(req_size)) - 4'd1)) != 3'd0)
             || (req_addr > 64'(MEM_SIZE - 8));

    assign req_ready   = state == IDLE && !reset;
    assign mem_address = addr;

    lsu_align u_align (
        .size   (size),
        .sign   (sign),
        .raw    (mem_d_out),
        .wdata  (wdata),
        .old    (mem_d_out),
        .rdata  (ext_data),
        .merged (merge_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            size       <= '0;
            sign       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_d_in   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr       <= req_addr;
                    size       <= req_size;
                    sign       <= req_signed;
                    write      <= req_write;
                    wdata      <= req_wdata;
                    resp_rdata <= '0;
                    if (fault) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                    end else if (req_write && req_size == SZ_D) begin
                        state     <= WRITE;
                        mem_write <= 1'b1;
                        mem_d_in  <= req_wdata;
                    end else begin
                        state    <= READ;
                        mem_read <= 1'b1;
                    end
                end
                READ: begin
                    mem_read <= 1'b0;
                    if (write) begin
                        state     <= WRITE;
                        mem_write <= 1'b1;
                        mem_d_in  <= merge_data;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ext_data;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    mem_write  <= 1'b0;
                    mem_d_in   <= '0;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit.
// The bench uses a byte-array memory and a byte-level reference model.
module tb_load_store_unit;

    localparam int MS = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        preload = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_fault, mem_read, mem_write;
    logic [63:0] resp_rdata, mem_address, mem_d_in, mem_d_out;

    logic [7:0] mem [MS];
    logic [7:0] ref_mem [MS];
    int  errors = 0, checks = 0;
    int  rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0, din_bad = 0;
    time last_rd_t = 0, last_wr_t = 0;

    load_store_unit #(.MEM_SIZE(MS)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_address(mem_address),
        .mem_d_in(mem_d_in), .mem_read(mem_read), .mem_write(mem_write), .mem_d_out(mem_d_out)
    );

    always #5 clock = ~clock;

    always_comb begin
        mem_d_out = '0;
        for (int i = 0; i < 8; i++) mem_d_out[8*i +: 8] = mem[(int'(mem_address[7:0]) + i) % MS];
    end

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < MS; i++) mem[i] <= ref_mem[i];
        end else if (mem_write) begin
            for (int i = 0; i < 8; i++) mem[(int'(mem_address[7:0]) + i) % MS] <= mem_d_in[8*i +: 8];
        end
    end

    always @(posedge clock) begin
        if (mem_read) begin rd_cnt <= rd_cnt + 1; last_rd_t <= $time; end
        if (mem_write) begin wr_cnt <= wr_cnt + 1; last_wr_t <= $time; end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    always @(negedge clock) if (!mem_write && mem_d_in !== 64'd0) din_bad <= din_bad + 1;

    function automatic logic [63:0] ref_load(input int a, input int n, input logic sg);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
        if (sg && n < 8 && ref_mem[a + n - 1][7])
            for (int i = n; i < 8; i++) v = v | (64'hFF << (8 * i));
        return v;
    endfunction

    task automatic ref_store(input int a, input int n, input logic [63:0] wd);
        for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                          input logic [63:0] wd, output logic [63:0] rd, output logic f,
                          output int lat, output int busy, output int nr, output int nw);
        int r0, w0;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        r0 = rd_cnt; w0 = wr_cnt;
        lat = 99; busy = 0; rd = '0; f = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (!req_ready) busy++;
            if (resp_valid && lat == 99) begin lat = i; rd = resp_rdata; f = resp_fault; end
            if (req_ready) break;
        end
        nr = rd_cnt - r0; nw = wr_cnt - w0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++; if ({mem_read, mem_write, resp_valid, resp_fault} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 0000", {mem_read, mem_write, resp_valid, resp_fault}); end
        checks++; if ((mem_d_in | mem_address | resp_rdata) !== 64'd0) begin
            errors++; $display("FAIL reset_data: d_in %h addr %h rdata %h want 0", mem_d_in, mem_address, resp_rdata); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_loads();
        logic [63:0] rd; logic f; int lat, busy, nr, nw;
        do_req(1'b0, 2'd0, 1'b1, 64'h17, '0, rd, f, lat, busy, nr, nw);
        checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF88 || f !== 1'b0) begin
            errors++; $display("FAIL lb_signed: got %h/%b want ffffffffffffff88/0", rd, f); end
        checks++; if (lat != 2 || nr != 1 || nw != 0) begin
            errors++; $display("FAIL lb_timing: lat %0d reads %0d writes %0d want 2 1 0", lat, nr, nw); end
        do_req(1'b0, 2'd1, 1'b0, 64'h16, '0, rd, f, lat, busy, nr, nw);
        checks++; if (rd !== 64'h8877) begin errors++; $display("FAIL lhu: got %h want 8877", rd); end
        do_req(1'b0, 2'd2, 1'b1, 64'h14, '0, rd, f, lat, busy, nr, nw);
        checks++; if (rd !== 64'hFFFF_FFFF_8877_6655) begin errors++; $display("FAIL lw_signed: got %h want ffffffff88776655", rd); end
    endtask

    task automatic test_store_rmw();
        logic [63:0] rd, keep; logic f; int lat, busy, nr, nw;
        keep = ref_load(16'h18, 2, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 64'h12, 64'hAB, rd, f, lat, busy, nr, nw);
        ref_store(16'h12, 1, 64'hAB);
        checks++; if (lat != 3 || nr != 1 || nw != 1 || rd !== 64'd0 || f !== 1'b0) begin
            errors++; $display("FAIL sb_txn: lat %0d reads %0d writes %0d rdata %h fault %b want 3 1 1 0 0", lat, nr, nw, rd, f); end
        checks++; if (!(last_rd_t < last_wr_t)) begin errors++; $display("FAIL sb_order: read at %0t write at %0t", last_rd_t, last_wr_t); end
        do_req(1'b0, 2'd3, 1'b0, 64'h10, '0, rd, f, lat, busy, nr, nw);
        checks++; if (rd !== 64'h8877_6655_44AB_2211) begin errors++; $display("FAIL sb_result: got %h want 8877665544ab2211", rd); end
        do_req(1'b0, 2'd1, 1'b0, 64'h18, '0, rd, f, lat, busy, nr, nw);
        checks++; if (rd !== keep) begin errors++; $display("FAIL sb_neighbours: got %h want %h", rd, keep); end
    endtask

    task automatic test_faults();
        logic [63:0] rd; logic f; int lat, busy, nr, nw;
        do_req(1'b0, 2'd2, 1'b0, 64'h12, '0, rd, f, lat, busy, nr, nw);
        checks++; if (f !== 1'b1 || rd !== 64'd0 || lat != 1 || nr != 0 || nw != 0) begin
            errors++; $display("FAIL fault_misaligned: fault %b rdata %h lat %0d r %0d w %0d want 1 0 1 0 0", f, rd, lat, nr, nw); end
        do_req(1'b0, 2'd0, 1'b0, 64'hF9, '0, rd, f, lat, busy, nr, nw);
        checks++; if (f !== 1'b1 || rd !== 64'd0 || lat != 1 || nr != 0 || nw != 0) begin
            errors++; $display("FAIL fault_range: fault %b rdata %h lat %0d r %0d w %0d want 1 0 1 0 0", f, rd, lat, nr, nw); end
    endtask

    task automatic test_double();
        logic [63:0] rd; logic f; int lat, busy, nr, nw;
        do_req(1'b1, 2'd3, 1'b0, 64'h20, 64'h0123_4567_89AB_CDEF, rd, f, lat, busy, nr, nw);
        ref_store(32, 8, 64'h0123_4567_89AB_CDEF);
        checks++; if (busy != 2 || lat != 2 || nr != 0 || nw != 1) begin
            errors++; $display("FAIL sd_txn: busy %0d lat %0d r %0d w %0d want 2 2 0 1", busy, lat, nr, nw); end
        do_req(1'b0, 2'd3, 1'b1, 64'h20, '0, rd, f, lat, busy, nr, nw);
        checks++; if (rd !== 64'h0123_4567_89AB_CDEF || busy != 2) begin
            errors++; $display("FAIL ld_back: got %h busy %0d want 0123456789abcdef busy 2", rd, busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd, wd, exp; logic f, w, sg, ef; logic [1:0] sz; int lat, busy, nr, nw, a, n, elat;
        for (int k = 0; k < 60; k++) begin
            sz = 2'($urandom_range(0, 3)); n = 1 << sz;
            a = $urandom_range(0, 263);
            if ($urandom_range(0, 3) != 0) a = a & ~(n - 1);
            w = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            ef = (a % n != 0) || (a > MS - 8);
            exp = (ef || w) ? 64'd0 : ref_load(a, n, sg);
            elat = ef ? 1 : (w && n < 8) ? 3 : 2;
            do_req(w, sz, sg, 64'(a), wd, rd, f, lat, busy, nr, nw);
            if (!ef && w) ref_store(a, n, wd);
            checks++; if (f !== ef || rd !== exp) begin
                errors++; $display("FAIL rand_resp[%0d]: addr %0h size %0d w %b got %h/%b want %h/%b", k, a, sz, w, rd, f, exp, ef); end
            checks++; if (lat != elat || nr != int'(!ef && (!w || n < 8)) || nw != int'(!ef && w)) begin
                errors++; $display("FAIL rand_timing[%0d]: lat %0d r %0d w %0d want lat %0d", k, lat, nr, nw, elat); end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] rd; logic f; int lat, busy, nr, nw, w0, c0;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 64'h12; req_wdata = 64'h5A;
        w0 = wr_cnt; c0 = resp_cnt;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL abort_in_write: mem_write %b want 1", mem_write); end
        reset = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL abort_drop: mem_write %b ready %b want 0 0", mem_write, req_ready); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1 || resp_cnt != c0 || wr_cnt != w0) begin
            errors++; $display("FAIL abort_after: ready %b resps %0d writes %0d want 1 0 0", req_ready, resp_cnt - c0, wr_cnt - w0); end
        do_req(1'b0, 2'd3, 1'b0, 64'h10, '0, rd, f, lat, busy, nr, nw);
        checks++; if (rd !== ref_load(16, 8, 1'b0)) begin errors++; $display("FAIL abort_mem: got %h want %h", rd, ref_load(16, 8, 1'b0)); end
    endtask

    task automatic test_invariants();
        int bad;
        bad = 0;
        for (int i = 0; i < MS; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL mem_image: %0d bytes differ want 0", bad); end
        checks++; if (both_cnt != 0 || din_bad != 0) begin
            errors++; $display("FAIL strobe_rules: overlap %0d d_in_outside_write %0d want 0 0", both_cnt, din_bad); end
    endtask

    initial begin
        for (int i = 0; i < MS; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) ref_mem[16 + i] = 8'(8'h11 * (i + 1));
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        preload = 1'b0;
        test_reset();
        test_loads();
        test_store_rmw();
        test_faults();
        test_double();
        test_back_to_back();
        test_reset_mid_write();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
